// File: rtl/exe_mdu_if.sv
// exe_mdu_if: request/operand and handshake/result bus between execute stage and multiply/divide engine
interface exe_mdu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             kill;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, op, opA, opB, kill,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  start, op, opA, opB, kill,
        output busy, done, hi, lo, dz
    );
endinterface

// File: rtl/exe_mdu.sv
// exe_mdu: iterative shift-add multiplier / restoring divider with signed modes, divide-by-zero flag and flush abort
module exe_mdu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst_n,
    exe_mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   b;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz_p;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               accept;
    logic               div_zero;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     mul_t;
    logic [WIDTH:0]     sh;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH:0]     acc_n;
    logic [WIDTH-1:0]   q_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // operand conditioning: signed ops run on magnitudes, signs are reapplied in FIX
    assign accept   = bus.start && !bus.kill;
    assign div_zero = bus.op[1] && (bus.opB == '0);
    assign sa       = bus.op[0] && bus.opA[WIDTH-1];
    assign sb       = bus.op[0] && bus.opB[WIDTH-1];
    assign ma       = sa ? -bus.opA : bus.opA;
    assign mb       = sb ? -bus.opB : bus.opB;

    // multiply step: {acc,q} holds partial product and remaining multiplier bits
    assign sum   = acc + {1'b0, b};
    assign mul_t = q[0] ? sum : acc;

    // divide step: acc is the partial remainder, q shifts dividend out and quotient in
    assign sh    = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign ge    = sh >= {1'b0, b};
    assign diff  = sh - {1'b0, b};

    assign acc_n = is_div ? (ge ? diff : sh) : {1'b0, mul_t[WIDTH:1]};
    assign q_n   = is_div ? {q[WIDTH-2:0], ge} : {mul_t[0], q[WIDTH-1:1]};

    // sign correction; most-negative / -1 wraps back to most-negative naturally
    assign prod   = neg_lo ? -{acc[WIDTH-1:0], q} : {acc[WIDTH-1:0], q};
    assign quo    = neg_lo ? -q : q;
    assign rem    = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign res_hi = dz_p ? q  : (is_div ? rem : prod[2*WIDTH-1:WIDTH]);
    assign res_lo = dz_p ? '1 : (is_div ? quo : prod[WIDTH-1:0]);

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.dz   = dz_r;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state: divide-by-zero skips iteration, kill aborts anything in flight
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = div_zero ? FIX : RUN;
            RUN:     state_n = bus.kill ? IDLE : ((cnt == '0) ? FIX : RUN);
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // datapath iteration and registered results; results only load when FIX completes unkilled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            b      <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz_p   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            busy_r <= state_n != IDLE;
            done_r <= (state == FIX) && !bus.kill;
            if (state == IDLE && accept) begin
                cnt    <= CNT_W'(WIDTH - 1);
                acc    <= '0;
                q      <= div_zero ? bus.opA : ma;
                b      <= mb;
                is_div <= bus.op[1];
                neg_lo <= sa ^ sb;
                neg_hi <= sa;
                dz_p   <= div_zero;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
                acc <= acc_n;
                q   <= q_n;
            end
            if (state == FIX && !bus.kill) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
                dz_r <= dz_p;
            end
        end
    end
endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu: directed and random scoreboard bench for the multiply/divide engine
module tb_exe_mdu;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    exe_mdu_if #(.WIDTH(W)) bus ();
    exe_mdu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        res_t   e;
        sa = o[0] ? longint'($signed(a)) : longint'(a);
        sb = o[0] ? longint'($signed(b)) : longint'(b);
        if (!o[1]) begin
            r = sa * sb;
            e.hi = r[2*W-1:W];
            e.lo = r[W-1:0];
            e.dz = 1'b0;
        end else if (sb == 0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            r = sa / sb;
            e.lo = r[W-1:0];
            r = sa % sb;
            e.hi = r[W-1:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
        bus.op    = o;
        bus.opA   = a;
        bus.opB   = b;
        bus.start = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic finish_op(input string tag, input int lat);
        int   n;
        res_t e;
        tick;
        bus.start = 1'b0;
        n = 1;
        chk({tag, "_done_low"}, bus.done, 0);
        while (bus.done !== 1'b1 && n < lat + 4) begin
            chk({tag, "_busy"}, bus.busy, 1);
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        e = sb_q.pop_front();
        chk({tag, "_hi"}, bus.hi, e.hi);
        chk({tag, "_lo"}, bus.lo, e.lo);
        chk({tag, "_dz"}, bus.dz, e.dz);
        chk({tag, "_busy_end"}, bus.busy, 0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        res_t         e;
        int           dn, dcyc;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = 2'b00;
        bus.opA   = '0;
        bus.opB   = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_dz", bus.dz, 0);
        rst_n = 1'b1;
        tick;

        issue(2'b00, 16'hFFFF, 16'hFFFF, res_t'{16'hFFFE, 16'h0001, 1'b0});
        finish_op("mulu_max", 18);
        tick;
        chk("mulu_pulse_end", bus.done, 0);
        chk("mulu_idle_busy", bus.busy, 0);

        issue(2'b01, 16'hFFFE, 16'h0003, res_t'{16'hFFFF, 16'hFFFA, 1'b0});
        finish_op("muls", 18);
        issue(2'b11, 16'hFFF9, 16'h0002, res_t'{16'hFFFF, 16'hFFFD, 1'b0});
        finish_op("divs_b2b", 18);

        issue(2'b10, 16'h0064, 16'h0000, res_t'{16'h0064, 16'hFFFF, 1'b1});
        finish_op("divu_zero", 2);
        issue(2'b10, 16'h0064, 16'h0007, res_t'{16'h0002, 16'h000E, 1'b0});
        finish_op("divu", 18);

        issue(2'b11, 16'h8000, 16'hFFFF, res_t'{16'h0000, 16'h8000, 1'b0});
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        bus.op    = 2'b00;
        bus.opA   = 16'h0005;
        bus.opB   = 16'h0005;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        dn = 0;
        dcyc = 0;
        for (int c = 6; c <= 30; c++) begin
            if (bus.done === 1'b1) begin
                dn++;
                if (dn == 1) begin
                    dcyc = c;
                    e = sb_q.pop_front();
                    chk("divs_ovf_hi", bus.hi, e.hi);
                    chk("divs_ovf_lo", bus.lo, e.lo);
                    chk("divs_ovf_dz", bus.dz, e.dz);
                end
            end
            tick;
        end
        sb_q.delete();
        chk("ignored_start_dones", dn, 1);
        chk("divs_ovf_latency", dcyc, 18);
        chk("ignored_start_idle", bus.busy, 0);

        bus.op    = 2'b00;
        bus.opA   = 16'h1234;
        bus.opB   = 16'h0010;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        bus.kill = 1'b1;
        tick;
        bus.kill = 1'b0;
        chk("kill_run_busy", bus.busy, 0);
        chk("kill_run_done", bus.done, 0);
        chk("kill_run_hi", bus.hi, 16'h0000);
        chk("kill_run_lo", bus.lo, 16'h8000);
        issue(2'b00, 16'h1234, 16'h0010, res_t'{16'h0001, 16'h2340, 1'b0});
        chk("kill_no_late_done", bus.done, 0);
        finish_op("mul_after_kill", 18);

        bus.op    = 2'b00;
        bus.opA   = 16'h0003;
        bus.opB   = 16'h0005;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (16) tick;
        bus.kill = 1'b1;
        tick;
        bus.kill = 1'b0;
        chk("kill_fix_done", bus.done, 0);
        chk("kill_fix_busy", bus.busy, 0);
        chk("kill_fix_hi", bus.hi, 16'h0001);
        chk("kill_fix_lo", bus.lo, 16'h2340);

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = (i == 4) ? '0 : W'($urandom);
            issue(ro, ra, rb, model(ro, ra, rb));
            finish_op("rand", (ro[1] && rb == '0) ? 2 : 18);
        end

        issue(2'b00, 16'hFFFF, 16'hFFFF, res_t'{16'hFFFE, 16'h0001, 1'b0});
        finish_op("pre_reset", 18);
        bus.op    = 2'b01;
        bus.opA   = 16'h7123;
        bus.opB   = 16'h0456;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", bus.busy, 0);
        chk("areset_done", bus.done, 0);
        chk("areset_hi", bus.hi, 0);
        chk("areset_lo", bus.lo, 0);
        chk("areset_dz", bus.dz, 0);
        tick;
        #2;
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 25; c++) begin
            tick;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
        end
        chk("no_spurious_after_reset", dn, 0);

        bus.op    = 2'b00;
        bus.opA   = 16'h0003;
        bus.opB   = 16'h0003;
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        chk("kill_start_idle_busy", bus.busy, 0);
        tick;
        chk("kill_start_idle_busy2", bus.busy, 0);
        chk("kill_start_idle_done", bus.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
